// File: rtl/time_set_ctrl_if.sv
// Button, live-time and load signals between the front panel and the time-set sequencer.
// The panel side (master) drives buttons and live time; the sequencer (slave) drives the load outputs.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_set;
    logic       btn_up;
    logic       btn_down;
    logic       btn_cancel;
    logic       btn_mode;
    logic [4:0] cur_hrs;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       clk_switch;
    logic [2:0] clk_mode;
    logic [4:0] set_hrs;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic [1:0] edit_field;
    logic       blink;

    modport master (
        output tick_1hz, btn_set, btn_up, btn_down, btn_cancel, btn_mode,
        output cur_hrs, cur_min, cur_sec,
        input  clk_switch, clk_mode, set_hrs, set_min, set_sec, edit_field, blink
    );

    modport slave (
        input  tick_1hz, btn_set, btn_up, btn_down, btn_cancel, btn_mode,
        input  cur_hrs, cur_min, cur_sec,
        output clk_switch, clk_mode, set_hrs, set_min, set_sec, edit_field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Front-panel time-set sequencer: edits hrs/min/sec from button pulses, then loads the Clock core.
// Define AUTO_EXIT_EN to abandon an idle edit after TIMEOUT_TICKS seconds without a button.
//
// state   | meaning
// RUN     | clock running, btn_set starts an edit, btn_mode cycles the mode
// SET_HRS | editing hours
// SET_MIN | editing minutes
// SET_SEC | editing seconds
// COMMIT  | clk_switch held high for LOAD_CYCLES clks, then back to RUN
module time_set_ctrl #(
    parameter int HRS_MAX       = 23,
    parameter int MIN_MAX       = 59,
    parameter int MODE_COUNT    = 4,
    parameter int LOAD_CYCLES   = 2,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic          clk,
    input  logic          reset,
    time_set_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HRS = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam logic [5:0] HRS_TOP   = 6'(HRS_MAX);
    localparam logic [5:0] MIN_TOP   = 6'(MIN_MAX);
    localparam logic [2:0] MODE_LAST = 3'(MODE_COUNT - 1);
    localparam int         LCW       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);

    state_t         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [4:0]     hrs_q, hrs_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic           switch_q, switch_d;
    logic [1:0]     field_q, field_d;
    logic           blink_q, blink_d;
    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic           in_set_d;
    logic           inc, dec;

`ifdef AUTO_EXIT_EN
    localparam int             TCW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_TICKS - 1);

    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           any_btn;
    logic           tmo_hit;
`endif

    // Out-of-range values (possible when seeded from the core) snap to a legal value on the first step.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up && !dn) begin
            r = (v >= top) ? 6'd0 : v + 6'd1;
        end else if (dn && !up) begin
            r = (v == 6'd0 || v > top) ? top : v - 6'd1;
        end
        return r;
    endfunction

    assign inc = bus.btn_up;
    assign dec = bus.btn_down;

`ifdef AUTO_EXIT_EN
    assign any_btn = bus.btn_set | bus.btn_up | bus.btn_down | bus.btn_cancel | bus.btn_mode;
    assign tmo_hit = !any_btn && bus.tick_1hz && (tmo_cnt_q == TMO_LAST);
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        hrs_d      = hrs_q;
        min_d      = min_q;
        sec_d      = sec_q;
        load_cnt_d = load_cnt_q;

        unique case (state_q)
            RUN: begin
                if (bus.btn_set) begin
                    state_d = SET_HRS;
                    hrs_d   = bus.cur_hrs;
                    min_d   = bus.cur_min;
                    sec_d   = bus.cur_sec;
                end
                if (bus.btn_mode) begin
                    mode_d = (mode_q >= MODE_LAST) ? 3'd0 : mode_q + 3'd1;
                end
            end

            SET_HRS, SET_MIN, SET_SEC: begin
                if (bus.btn_cancel) begin
                    state_d = RUN;
                end else if (bus.btn_set) begin
                    unique case (state_q)
                        SET_HRS: state_d = SET_MIN;
                        SET_MIN: state_d = SET_SEC;
                        default: begin
                            state_d    = COMMIT;
                            load_cnt_d = LOAD_LAST;
                        end
                    endcase
                end else begin
                    unique case (state_q)
                        SET_HRS: hrs_d = 5'(wrap_step({1'b0, hrs_q}, HRS_TOP, inc, dec));
                        SET_MIN: min_d = wrap_step(min_q, MIN_TOP, inc, dec);
                        default: sec_d = wrap_step(sec_q, MIN_TOP, inc, dec);
                    endcase
`ifdef AUTO_EXIT_EN
                    if (tmo_hit) begin
                        state_d = RUN;
                    end
`endif
                end
            end

            COMMIT: begin
                if (load_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    load_cnt_d = load_cnt_q - 1'b1;
                end
            end

            default: state_d = RUN;
        endcase
    end

    // Output registers are derived from the next state so every output is a flop.
    always_comb begin
        in_set_d = (state_d == SET_HRS) || (state_d == SET_MIN) || (state_d == SET_SEC);
        switch_d = (state_d == COMMIT);

        field_d = 2'd0;
        unique case (state_d)
            SET_HRS: field_d = 2'd1;
            SET_MIN: field_d = 2'd2;
            SET_SEC: field_d = 2'd3;
            default: field_d = 2'd0;
        endcase

        blink_d = 1'b0;
        if (in_set_d && (state_d == state_q)) begin
            blink_d = bus.tick_1hz ? ~blink_q : blink_q;
        end
    end

`ifdef AUTO_EXIT_EN
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!in_set_d || state_q == RUN || any_btn) begin
            tmo_cnt_d = '0;
        end else if (bus.tick_1hz) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            mode_q     <= '0;
            hrs_q      <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            switch_q   <= 1'b0;
            field_q    <= '0;
            blink_q    <= 1'b0;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            hrs_q      <= hrs_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            switch_q   <= switch_d;
            field_q    <= field_d;
            blink_q    <= blink_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    assign bus.clk_switch = switch_q;
    assign bus.clk_mode   = mode_q;
    assign bus.set_hrs    = hrs_q;
    assign bus.set_min    = min_q;
    assign bus.set_sec    = sec_q;
    assign bus.edit_field = field_q;
    assign bus.blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed scoreboard bench for time_set_ctrl; with AUTO_EXIT_EN defined it also covers the idle timeout (3 ticks).
module tb_time_set_ctrl;

`ifdef AUTO_EXIT_EN
    localparam int TMO = 3;
`else
    localparam int TMO = 30;
`endif

    localparam logic [5:0] B_SET  = 6'h01;
    localparam logic [5:0] B_UP   = 6'h02;
    localparam logic [5:0] B_DN   = 6'h04;
    localparam logic [5:0] B_CAN  = 6'h08;
    localparam logic [5:0] B_MODE = 6'h10;
    localparam logic [5:0] B_TICK = 6'h20;

    typedef struct {
        logic       sw;
        logic [2:0] mode;
        logic [4:0] hrs;
        logic [5:0] min;
        logic [5:0] sec;
        logic [1:0] field;
        logic       blink;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t x;
    exp_t sb_q[$];

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .HRS_MAX(23), .MIN_MAX(59), .MODE_COUNT(4), .LOAD_CYCLES(2), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] b);
        bus.btn_set    = b[0];
        bus.btn_up     = b[1];
        bus.btn_down   = b[2];
        bus.btn_cancel = b[3];
        bus.btn_mode   = b[4];
        bus.tick_1hz   = b[5];
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("clk_switch", 32'(bus.clk_switch), 32'(e.sw));
            check_val("clk_mode",   32'(bus.clk_mode),   32'(e.mode));
            check_val("set_hrs",    32'(bus.set_hrs),    32'(e.hrs));
            check_val("set_min",    32'(bus.set_min),    32'(e.min));
            check_val("set_sec",    32'(bus.set_sec),    32'(e.sec));
            check_val("edit_field", 32'(bus.edit_field), 32'(e.field));
            check_val("blink",      32'(bus.blink),      32'(e.blink));
        end
    endtask

    task automatic apply(input logic [5:0] b);
        drive(b);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        drive(6'h00);
        compare_out();
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hrs = 5'(h);
        bus.cur_min = 6'(m);
        bus.cur_sec = 6'(s);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        x = '{default: '0};
        drive(6'h00);
        set_cur(12, 34, 56);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(x);
        compare_out();
        reset = 1'b0;

        // enter edit, seed from live time
        x.field = 2'd1; x.hrs = 5'd12; x.min = 6'd34; x.sec = 6'd56;
        apply(B_SET);
        x.blink = 1'b1;
        apply(B_TICK);
        for (int h = 13; h <= 23; h++) begin
            x.hrs = 5'(h);
            apply(B_UP);
        end
        x.hrs = 5'd0;  apply(B_UP);
        x.hrs = 5'd23; apply(B_DN);
        x.hrs = 5'd22; apply(B_DN);
        x.hrs = 5'd23; apply(B_UP);
        apply(B_UP | B_DN);
        apply(B_MODE);
        x.blink = 1'b0;
        apply(B_TICK);

        x.field = 2'd2;
        apply(B_SET);
        for (int m = 33; m >= 0; m--) begin
            x.min = 6'(m);
            apply(B_DN);
        end
        x.min = 6'd59; apply(B_DN);
        apply(B_UP | B_DN);

        x.field = 2'd3;
        apply(B_SET);
        x.sec = 6'd55;
        apply(B_DN);

        // commit: switch high for exactly two clocks, buttons ignored
        x.field = 2'd0; x.sw = 1'b1;
        apply(B_SET);
        apply(B_CAN | B_UP | B_DN | B_SET);
        x.sw = 1'b0;
        apply(6'h00);
        apply(6'h00);

        for (int i = 1; i <= 4; i++) begin
            x.mode = 3'(i % 4);
            apply(B_MODE);
        end
        apply(B_UP);
        apply(B_DN);
        apply(B_CAN);
        apply(B_TICK);

        // cancel wins over set
        set_cur(1, 2, 3);
        x.field = 2'd1; x.hrs = 5'd1; x.min = 6'd2; x.sec = 6'd3;
        apply(B_SET);
        x.field = 2'd2;
        apply(B_SET);
        x.field = 2'd0;
        apply(B_SET | B_CAN);
        apply(6'h00);

        // idle ticks in SET_MIN, with a button after two ticks
        x.field = 2'd1;
        apply(B_SET);
        x.field = 2'd2;
        apply(B_SET);
        x.blink = 1'b1; apply(B_TICK);
        x.blink = 1'b0; apply(B_TICK);
        x.min = 6'd3;   apply(B_UP);
        x.blink = 1'b1; apply(B_TICK);
        x.blink = 1'b0; apply(B_TICK);
`ifdef AUTO_EXIT_EN
        x.field = 2'd0;
        apply(B_TICK);
        apply(6'h00);
`else
        x.blink = 1'b1;
        apply(B_TICK);
        x.field = 2'd0; x.blink = 1'b0;
        apply(B_CAN);
`endif

        // reset in the middle of a commit
        x.field = 2'd1; x.hrs = 5'd1; x.min = 6'd2; x.sec = 6'd3;
        apply(B_SET);
        x.field = 2'd2; apply(B_SET);
        x.field = 2'd3; apply(B_SET);
        x.field = 2'd0; x.sw = 1'b1;
        apply(B_SET);
        reset = 1'b1;
        #1;
        x = '{default: '0};
        sb_q.push_back(x);
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        apply(6'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
